// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/add ops, iterative shifts (one bit per cycle)
// and shift-add MUL. States: IDLE accept | BUSY iterate | DONE hold result.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             parity,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = IMM_W - 1;
    // Counter must hold both WIDTH (MUL) and the largest shift amount.
    localparam int CW    = (CNT_W > SH_W) ? CNT_W : SH_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_PASSI = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SHF   = 3'b111;

    logic [1:0]         r_state;
    logic               r_is_mul;
    logic               r_dir;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_neg;
    logic               r_par;

    logic               w_idle;
    logic               w_accept;
    logic               w_multi;
    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH-1:0]   w_imm_ext;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_c;
    logic [CW-1:0]      w_cnt_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic               w_shc_nxt;
    logic [WIDTH-1:0]   w_ld_res;
    logic               w_ld_c;

    assign w_idle    = (r_state != S_BUSY) && (r_state != S_DONE);
    assign w_accept  = w_idle && in_valid && !flush;
    assign w_shamt   = imm[SH_W-1:0];
    assign w_imm_ext = WIDTH'(imm);
    assign w_multi   = (opcode == OP_MUL) || ((opcode == OP_SHF) && (w_shamt != '0));

    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        case (opcode)
            OP_AND:   w_sc_res = operand1 & operand2;
            OP_ADDI:  {w_sc_c, w_sc_res} = {1'b0, operand1} + {1'b0, w_imm_ext};
            OP_XOR:   w_sc_res = operand1 ^ operand2;
            OP_ADD:   {w_sc_c, w_sc_res} = {1'b0, operand1} + {1'b0, operand2};
            OP_PASSI: w_sc_res = w_imm_ext;
            OP_SUB:   {w_sc_c, w_sc_res} = {1'b0, operand1} - {1'b0, operand2};
            OP_SHF:   w_sc_res = operand1;
            default:  w_sc_res = '0;
        endcase
    end

    assign w_cnt_nxt = r_cnt - 1'b1;
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_sh_nxt  = r_dir ? (r_sh >> 1) : (r_sh << 1);
    assign w_shc_nxt = r_dir ? r_sh[0] : r_sh[WIDTH-1];

    always_comb begin
        w_ld_res = w_sc_res;
        w_ld_c   = w_sc_c;
        if (r_state == S_BUSY) begin
            if (r_is_mul) begin
                w_ld_res = w_acc_nxt[WIDTH-1:0];
                w_ld_c   = |w_acc_nxt[2*WIDTH-1:WIDTH];
            end else begin
                w_ld_res = w_sh_nxt;
                w_ld_c   = w_shc_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_is_mul <= 1'b0;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sh     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_par    <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt    <= w_cnt_nxt;
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_sh     <= w_sh_nxt;
                        if (w_cnt_nxt == '0) begin
                            r_state  <= S_DONE;
                            r_result <= w_ld_res;
                            r_zero   <= (w_ld_res == '0);
                            r_carry  <= w_ld_c;
                            r_neg    <= w_ld_res[WIDTH-1];
                            r_par    <= ^w_ld_res;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        if (w_multi) begin
                            r_state  <= S_BUSY;
                            r_is_mul <= (opcode == OP_MUL);
                            r_dir    <= imm[IMM_W-1];
                            r_cnt    <= (opcode == OP_MUL) ? CW'(WIDTH) : CW'(w_shamt);
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, operand1};
                            r_mplier <= operand2;
                            r_sh     <= operand1;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_ld_res;
                            r_zero   <= (w_ld_res == '0);
                            r_carry  <= w_ld_c;
                            r_neg    <= w_ld_res[WIDTH-1];
                            r_par    <= ^w_ld_res;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_idle;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign negative  = r_neg;
    assign parity    = r_par;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: random ops against a transaction-level model, plus
// directed cases with hand-computed results and latencies.
module tb_seq_alu;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   opcode = 3'd0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic [3:0]   imm = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, carry, negative, parity, busy;

    int checks = 0;
    int errors = 0;

    // model: 0 waiting for op, 1 computing, 2 holding result
    int m_phase = 0;
    int m_left  = 0;
    int m_pres  = 0;
    bit m_pc    = 0;
    int m_res   = 0;
    bit m_z = 0, m_c = 0, m_n = 0, m_p = 0;

    seq_alu #(.WIDTH(W), .IMM_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .negative(negative),
        .parity(parity), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_op(input int opc, input int a, input int b, input int im,
                                     output int res, output bit c, output int lat);
        int sh;
        int p;
        lat = 1;
        c   = 0;
        res = 0;
        sh  = im & 7;
        case (opc)
            0: res = a & b;
            1: begin res = a + im; c = ((res >> W) != 0); end
            2: res = a ^ b;
            3: begin res = a + b; c = ((res >> W) != 0); end
            4: begin p = a * b; res = p; c = ((p >> W) != 0); lat = W + 1; end
            5: res = im;
            6: begin res = a - b; c = (a < b); end
            default: begin
                lat = sh + 1;
                if (sh == 0) res = a;
                else if (im >= 8) begin res = a >> sh; c = ((a >> (sh - 1)) & 1) != 0; end
                else begin res = a << sh; c = ((a >> (W - sh)) & 1) != 0; end
            end
        endcase
        res = res & MASK;
    endfunction

    function automatic void set_vis(input int r, input bit c);
        m_res = r;
        m_c   = c;
        m_z   = (r == 0);
        m_n   = ((r >> (W - 1)) & 1) != 0;
        m_p   = ($countones(r) % 2) == 1;
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_left = 0; m_res = 0;
        m_z = 0; m_c = 0; m_n = 0; m_p = 0;
    endfunction

    function automatic void model_edge();
        int r; bit c; int lat;
        if (m_phase == 0) begin
            if (!flush && in_valid) begin
                model_op(int'(opcode), int'(operand1), int'(operand2), int'(imm), r, c, lat);
                if (lat == 1) begin
                    m_phase = 2;
                    set_vis(r, c);
                end else begin
                    m_phase = 1; m_left = lat - 1; m_pres = r; m_pc = c;
                end
            end
        end else if (m_phase == 1) begin
            if (flush) m_phase = 0;
            else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_phase = 2;
                    set_vis(m_pres, m_pc);
                end
            end
        end else if (flush || out_ready) begin
            m_phase = 0;
        end
    endfunction

    task automatic compare_all();
        logic [W+5:0] act, exp;
        logic [W-1:0] er;
        er  = m_res[W-1:0];
        act = {in_ready, out_valid, busy, result, zero, carry, negative, parity};
        exp = {m_phase == 0, m_phase == 2, m_phase == 1, er, m_z, m_c, m_n, m_p};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t {rdy,ov,busy,res,z,c,n,p} got=%h want=%h", $time, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic fl, input logic iv, input logic [2:0] opc,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] im, input logic ordy);
        @(negedge clk);
        flush = fl; in_valid = iv; opcode = opc;
        operand1 = a; operand2 = b; imm = im; out_ready = ordy;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_op(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] im, output int lat);
        step(1'b0, 1'b1, opc, a, b, im, 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0);
            lat++;
        end
    endtask

    task automatic release_out();
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        #2;
        model_reset();
        compare_all();
        lit("reset_in_ready", int'(in_ready), 1);
        lit("reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'b011, 8'hFF, 8'h01, 4'd0, lat);
        lit("add_lat", lat, 1);
        lit("add_res", int'(result), 8'h00);
        lit("add_zcp", int'({zero, carry, parity}), 3'b110);
        release_out();

        run_op(3'b110, 8'h05, 8'h07, 4'd0, lat);
        lit("sub_lat", lat, 1);
        lit("sub_res", int'(result), 8'hFE);
        lit("sub_czn", int'({carry, zero, negative}), 3'b101);
        release_out();

        run_op(3'b111, 8'h80, 8'h00, 4'b1011, lat);
        lit("shr_lat", lat, 4);
        lit("shr_res", int'(result), 8'h10);
        lit("shr_c", int'(carry), 0);
        release_out();

        run_op(3'b111, 8'h81, 8'h00, 4'b0001, lat);
        lit("shl_lat", lat, 2);
        lit("shl_res", int'(result), 8'h02);
        lit("shl_c", int'(carry), 1);
        release_out();

        run_op(3'b100, 8'h10, 8'h10, 4'd0, lat);
        lit("mul_lat", lat, 9);
        lit("mul_res", int'(result), 8'h00);
        lit("mul_zc", int'({zero, carry}), 2'b11);
        release_out();

        run_op(3'b100, 8'h0D, 8'h0B, 4'd0, lat);
        lit("mul2_res", int'(result), 8'h8F);
        lit("mul2_c", int'(carry), 0);
        release_out();

        // backpressure: result must hold while a second op is offered
        step(1'b0, 1'b1, 3'b011, 8'h12, 8'h34, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b010, 8'hAA, 8'h55, 4'd0, 1'b0);
        lit("bp_res", int'(result), 8'h46);
        lit("bp_in_ready", int'(in_ready), 0);
        step(1'b0, 1'b1, 3'b010, 8'hAA, 8'h55, 4'd0, 1'b1);
        step(1'b0, 1'b1, 3'b010, 8'hF0, 8'h0F, 4'd0, 1'b1);
        lit("bp_next_res", int'(result), 8'hFF);
        release_out();

        // flush in the third BUSY cycle of a MUL
        step(1'b0, 1'b1, 3'b100, 8'h33, 8'h07, 4'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
        lit("flush_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
        lit("flush_stale_res", int'(result), 8'hFF);

        // flush in IDLE beats in_valid
        step(1'b1, 1'b1, 3'b011, 8'h01, 8'h01, 4'd0, 1'b1);
        lit("idle_flush_noacc", int'(out_valid), 0);

        // reset in the middle of a long shift
        step(1'b0, 1'b1, 3'b111, 8'hFF, 8'h00, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);
        do_reset();
        lit("rst_mid_outs", int'({out_valid, busy, result, zero, carry, negative, parity}), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1);

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 7,
                 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
